fp_to_linear: RTL and testbench

Sequential converter from the lab's compact floating-point format (sign S, 3-bit exponent E, 4-bit significand F) back to a 12-bit two's-complement linear value D. It is the decode direction paired with the linear-to-floating-point converter, so `D = (-1)^S × F × 2^E`. It takes one code per handshake, builds the magnitude with one left shift per cycle, applies the sign, and holds the result until the consumer accepts it.

---
 rtl/fp_to_linear.sv | 75 +++++++
 tb/tb_fp_to_linear.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fp_to_linear.sv
// fp_to_linear: sequential S/E/F floating-point code to 12-bit two's-complement decoder
module fp_to_linear (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        S,
    input  logic [2:0]  E,
    input  logic [3:0]  F,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] D
);
    typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;
    state_t      state_q, state_d;
    logic        sgn_q, sgn_d;
    logic [10:0] mag_q, mag_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] d_q, d_d;
    logic        out_valid_q, out_valid_d;
    assign in_ready  = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign D         = d_q;
    // next state: latch code, shift one bit per cycle, apply sign, hold until taken
    always_comb begin
        state_d     = state_q;
        sgn_d       = sgn_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sgn_d   = S;
                mag_d   = {7'b0, F};
                cnt_d   = E;
                state_d = SHIFT;
            end
            SHIFT: if (cnt_q == 3'd0) begin
                state_d = SIGN;
            end else begin
                mag_d = mag_q << 1;
                cnt_d = cnt_q - 3'd1;
            end
            SIGN: begin
                d_d         = sgn_q ? (~{1'b0, mag_q} + 12'd1) : {1'b0, mag_q};
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers with synchronous reset that aborts any conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sgn_q       <= 1'b0;
            mag_q       <= 11'd0;
            cnt_q       <= 3'd0;
            d_q         <= 12'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sgn_q       <= sgn_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_fp_to_linear.sv
// tb_fp_to_linear: directed and random checks of fp_to_linear against an arithmetic model
module tb_fp_to_linear;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        S = 1'b0;
    logic [2:0]  E = 3'd0;
    logic [3:0]  F = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] D;
    int errors = 0;
    int checks = 0;

    fp_to_linear dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready), .D(D)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic s, input int e, input int f);
        int v;
        v = f * (1 << e);
        if (s) v = -v;
        return v[11:0];
    endfunction

    task automatic convert(input logic s, input logic [2:0] e, input logic [3:0] f, input string tag);
        int lat;
        int ev;
        chk({tag, " ready_before"}, in_ready, 1);
        S = s; E = e; F = f; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; S = ~s; E = ~e; F = ~f;
        chk({tag, " busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        ev = int'(e) + 2;
        chk({tag, " latency"}, lat, ev);
        chk({tag, " D"}, D, model(s, int'(e), int'(f)));
    endtask

    task automatic release_out(input string tag);
        logic [11:0] held;
        held = D;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " rel_valid"}, out_valid, 0);
        chk({tag, " rel_ready"}, in_ready, 1);
        chk({tag, " rel_D"}, D, held);
    endtask

    initial begin
        logic [11:0] held;
        int wait_n;
        // reset held two cycles
        tick();
        tick();
        chk("rst D", D, 12'h000);
        chk("rst valid", out_valid, 0);
        chk("rst ready", in_ready, 1);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle D", D, 12'h000);
        chk("idle valid", out_valid, 0);
        chk("idle ready", in_ready, 1);
        // directed extremes
        convert(1'b0, 3'd0, 4'd1, "p001");
        chk("p001 const", D, 12'h001);
        release_out("p001");
        convert(1'b0, 3'd7, 4'd15, "p780");
        chk("p780 const", D, 12'h780);
        release_out("p780");
        convert(1'b1, 3'd3, 4'd10, "nFB0");
        chk("nFB0 const", D, 12'hFB0);
        release_out("nFB0");
        convert(1'b1, 3'd0, 4'd1, "nFFF");
        chk("nFFF const", D, 12'hFFF);
        release_out("nFFF");
        convert(1'b1, 3'd7, 4'd15, "n880");
        chk("n880 const", D, 12'h880);
        release_out("n880");
        convert(1'b1, 3'd5, 4'd0, "nzero");
        chk("nzero const", D, 12'h000);
        release_out("nzero");
        convert(1'b0, 3'd4, 4'd11, "rt176");
        chk("rt176 const", D, 12'h0B0);
        // back-pressure hold with an ignored in_valid pulse
        held = D;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin S = 1'b0; E = 3'd1; F = 4'd3; in_valid = 1'b1; end
            tick();
            in_valid = 1'b0;
            chk("bp D", D, held);
            chk("bp valid", out_valid, 1);
            chk("bp ready", in_ready, 0);
        end
        release_out("bp");
        repeat (4) begin
            tick();
            chk("bp no_ghost", out_valid, 0);
        end
        // out_ready while idle does nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle out_ready", out_valid, 0);
        // reset mid-shift
        S = 1'b0; E = 3'd7; F = 4'd15; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst ready", in_ready, 1);
        chk("mid rst valid", out_valid, 0);
        chk("mid rst D", D, 12'h000);
        repeat (12) begin
            tick();
            chk("mid rst stale", out_valid, 0);
        end
        convert(1'b0, 3'd2, 4'd5, "after_rst");
        chk("after_rst const", D, 12'h014);
        // reset during DONE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("done rst valid", out_valid, 0);
        chk("done rst D", D, 12'h000);
        // reset beats simultaneous in_valid
        rst = 1'b1; in_valid = 1'b1; S = 1'b0; E = 3'd0; F = 4'd9;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        repeat (4) begin
            tick();
            chk("rst_vs_valid ready", in_ready, 1);
            chk("rst_vs_valid valid", out_valid, 0);
        end
        // randomized codes with random consumer delay
        repeat (40) begin
            convert(1'($urandom_range(1)), 3'($urandom_range(7)), 4'($urandom_range(15)), "rand");
            held = D;
            wait_n = $urandom_range(3);
            repeat (wait_n) begin
                tick();
                chk("rand hold", D, held);
            end
            release_out("rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
